// File: rtl/dma_burst_fsm.sv
// Burst DMA engine: reads up to BURST_LEN words into a local buffer, then writes them out,
// repeating until the requested length is moved, an agent error occurs or software aborts.
module dma_burst_fsm #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int LEN_WIDTH  = 16,
    parameter int BURST_LEN  = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_go,
    input  logic                  i_abort,
    input  logic [ADDR_WIDTH-1:0] i_src_addr,
    input  logic [ADDR_WIDTH-1:0] i_dest_addr,
    input  logic [LEN_WIDTH-1:0]  i_len,
    input  logic                  i_src_inc,
    input  logic                  i_dest_inc,
    output logic                  o_busy,
    output logic                  o_done_if_set,
    output logic                  o_err_if_set,
    output logic                  o_go_hw_we,
    output logic [LEN_WIDTH-1:0]  o_remaining,
    output logic                  o_start,
    output logic                  o_we,
    output logic [ADDR_WIDTH-1:0] o_addr,
    output logic [DATA_WIDTH-1:0] o_wdata,
    input  logic                  i_done,
    input  logic                  i_err,
    input  logic [DATA_WIDTH-1:0] i_rdata
);
    localparam int IDX_W  = $clog2(BURST_LEN + 1);
    localparam int BUF_AW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [ADDR_WIDTH-1:0] STEP        = ADDR_WIDTH'(DATA_WIDTH / 8);
    localparam logic [LEN_WIDTH-1:0]  BURST_LEN_L = LEN_WIDTH'(BURST_LEN);
    localparam logic [IDX_W-1:0]      BURST_LEN_I = IDX_W'(BURST_LEN);

    typedef enum logic [2:0] {
        IDLE, LATCH, READ_START, READ_WAIT, WRITE_START, WRITE_WAIT, FINISH
    } state_t;

    function automatic logic [IDX_W-1:0] chunk_of(input logic [LEN_WIDTH-1:0] len);
        if (len >= BURST_LEN_L) chunk_of = BURST_LEN_I;
        else                    chunk_of = IDX_W'(len);
    endfunction

    state_t                state_reg, state_next;
    logic                  go_d_reg;
    logic [ADDR_WIDTH-1:0] src_reg, src_next, dest_reg, dest_next;
    logic [LEN_WIDTH-1:0]  len_reg, len_next;
    logic                  src_inc_reg, src_inc_next, dest_inc_reg, dest_inc_next;
    logic [IDX_W-1:0]      chunk_reg, chunk_next, rd_idx_reg, rd_idx_next, wr_idx_reg, wr_idx_next;
    logic                  err_reg, err_next;
    logic [DATA_WIDTH-1:0] wdata_reg, wdata_next;
    logic [DATA_WIDTH-1:0] buf_mem [BURST_LEN];
    logic                  buf_we;

    logic                  go_edge;
    logic [IDX_W-1:0]      rd_idx_inc, wr_idx_inc;
    logic [LEN_WIDTH-1:0]  len_dec;

    assign go_edge    = i_go & ~go_d_reg;
    assign rd_idx_inc = rd_idx_reg + IDX_W'(1);
    assign wr_idx_inc = wr_idx_reg + IDX_W'(1);
    assign len_dec    = len_reg - LEN_WIDTH'(1);

    always_comb begin
        state_next    = state_reg;
        src_next      = src_reg;
        dest_next     = dest_reg;
        len_next      = len_reg;
        src_inc_next  = src_inc_reg;
        dest_inc_next = dest_inc_reg;
        chunk_next    = chunk_reg;
        rd_idx_next   = rd_idx_reg;
        wr_idx_next   = wr_idx_reg;
        err_next      = err_reg;
        wdata_next    = wdata_reg;
        buf_we        = 1'b0;
        case (state_reg)
            IDLE: if (go_edge) state_next = LATCH;
            LATCH: begin
                src_next      = i_src_addr;
                dest_next     = i_dest_addr;
                len_next      = i_len;
                src_inc_next  = i_src_inc;
                dest_inc_next = i_dest_inc;
                chunk_next    = chunk_of(i_len);
                rd_idx_next   = '0;
                wr_idx_next   = '0;
                err_next      = i_abort;
                if (i_abort || i_len == '0) state_next = FINISH;
                else                        state_next = READ_START;
            end
            READ_START: begin
                if (i_abort) begin
                    err_next   = 1'b1;
                    state_next = FINISH;
                end else begin
                    state_next = READ_WAIT;
                end
            end
            READ_WAIT: if (i_done) begin
                if (i_err) begin
                    err_next   = 1'b1;
                    state_next = FINISH;
                end else begin
                    buf_we      = 1'b1;
                    rd_idx_next = rd_idx_inc;
                    if (src_inc_reg) src_next = src_reg + STEP;
                    if (rd_idx_inc == chunk_reg) begin
                        // Prefetch word 0; bypass when it is the word being stored right now.
                        wr_idx_next = '0;
                        wdata_next  = (rd_idx_reg == '0) ? i_rdata : buf_mem[BUF_AW'(0)];
                        state_next  = WRITE_START;
                    end else begin
                        state_next = READ_START;
                    end
                end
            end
            WRITE_START: begin
                if (i_abort) begin
                    err_next   = 1'b1;
                    state_next = FINISH;
                end else begin
                    state_next = WRITE_WAIT;
                end
            end
            WRITE_WAIT: if (i_done) begin
                if (i_err) begin
                    err_next   = 1'b1;
                    state_next = FINISH;
                end else begin
                    len_next    = len_dec;
                    wr_idx_next = wr_idx_inc;
                    if (dest_inc_reg) dest_next = dest_reg + STEP;
                    if (wr_idx_inc != chunk_reg) begin
                        wdata_next = buf_mem[wr_idx_inc[BUF_AW-1:0]];
                        state_next = WRITE_START;
                    end else if (len_dec == '0) begin
                        state_next = FINISH;
                    end else begin
                        chunk_next  = chunk_of(len_dec);
                        rd_idx_next = '0;
                        state_next  = READ_START;
                    end
                end
            end
            FINISH:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_reg    <= IDLE;
            go_d_reg     <= 1'b0;
            src_reg      <= '0;
            dest_reg     <= '0;
            len_reg      <= '0;
            src_inc_reg  <= 1'b0;
            dest_inc_reg <= 1'b0;
            chunk_reg    <= '0;
            rd_idx_reg   <= '0;
            wr_idx_reg   <= '0;
            err_reg      <= 1'b0;
            wdata_reg    <= '0;
        end else begin
            state_reg    <= state_next;
            go_d_reg     <= i_go;
            src_reg      <= src_next;
            dest_reg     <= dest_next;
            len_reg      <= len_next;
            src_inc_reg  <= src_inc_next;
            dest_inc_reg <= dest_inc_next;
            chunk_reg    <= chunk_next;
            rd_idx_reg   <= rd_idx_next;
            wr_idx_reg   <= wr_idx_next;
            err_reg      <= err_next;
            wdata_reg    <= wdata_next;
        end
    end

    // Buffer storage carries no reset so it maps onto block RAM.
    always_ff @(posedge i_clk) begin
        if (buf_we) buf_mem[rd_idx_reg[BUF_AW-1:0]] <= i_rdata;
    end

    logic run, rd_phase, wr_phase;
    assign run      = ~i_rst;
    assign rd_phase = (state_reg == READ_START) || (state_reg == READ_WAIT);
    assign wr_phase = (state_reg == WRITE_START) || (state_reg == WRITE_WAIT);

    assign o_busy        = run && (state_reg != IDLE);
    assign o_done_if_set = run && (state_reg == FINISH) && !err_reg;
    assign o_err_if_set  = run && (state_reg == FINISH) && err_reg;
    assign o_go_hw_we    = run && (state_reg == LATCH);
    assign o_remaining   = run ? len_reg : '0;
    assign o_start       = run && !i_abort && ((state_reg == READ_START) || (state_reg == WRITE_START));
    assign o_we          = run && wr_phase;
    assign o_addr        = !run ? '0 : rd_phase ? src_reg : wr_phase ? dest_reg : '0;
    assign o_wdata       = (run && wr_phase) ? wdata_reg : '0;
endmodule

// File: tb/tb_dma_burst_fsm.sv
// Directed bench for dma_burst_fsm: a small agent model answers every o_start and logs it.
module tb_dma_burst_fsm;
    localparam int DW = 32, AW = 32, LW = 16, BL = 4;

    logic          clk = 1'b0;
    logic          i_rst = 1'b1, i_go = 1'b0, i_abort = 1'b0;
    logic [AW-1:0] i_src_addr = '0, i_dest_addr = '0;
    logic [LW-1:0] i_len = '0;
    logic          i_src_inc = 1'b0, i_dest_inc = 1'b0;
    logic          o_busy, o_done_if_set, o_err_if_set, o_go_hw_we, o_start, o_we;
    logic [LW-1:0] o_remaining;
    logic [AW-1:0] o_addr;
    logic [DW-1:0] o_wdata;
    logic          i_done = 1'b0, i_err = 1'b0;
    logic [DW-1:0] i_rdata = '0;

    always #5 clk = ~clk;

    dma_burst_fsm #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW), .BURST_LEN(BL)) dut (
        .i_clk(clk), .i_rst(i_rst), .i_go(i_go), .i_abort(i_abort),
        .i_src_addr(i_src_addr), .i_dest_addr(i_dest_addr), .i_len(i_len),
        .i_src_inc(i_src_inc), .i_dest_inc(i_dest_inc),
        .o_busy(o_busy), .o_done_if_set(o_done_if_set), .o_err_if_set(o_err_if_set),
        .o_go_hw_we(o_go_hw_we), .o_remaining(o_remaining), .o_start(o_start), .o_we(o_we),
        .o_addr(o_addr), .o_wdata(o_wdata), .i_done(i_done), .i_err(i_err), .i_rdata(i_rdata)
    );

    int checks = 0, failures = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // agent model and monitor state
    int          lat = 1, err_idx = -1, n_txn = 0, cnt = 0, cur_idx = 0, rd_seq = 0;
    logic        cur_we = 1'b0, clr = 1'b0;
    int          done_cnt = 0, err_cnt = 0, hwwe_cnt = 0, done_cyc = 0, go_cyc = 0;
    logic        log_we   [64];
    logic [31:0] log_addr [64];
    logic [31:0] log_wdata[64];
    int          log_cyc  [64];

    always @(negedge clk) begin
        i_done  = 1'b0;
        i_err   = 1'b0;
        i_rdata = '0;
        if (clr) begin
            n_txn = 0; cnt = 0; rd_seq = 0; done_cnt = 0; err_cnt = 0; hwwe_cnt = 0;
        end else begin
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    i_done = 1'b1;
                    i_err  = (cur_idx == err_idx);
                    if (!cur_we) begin
                        i_rdata = 32'hC0DE_0000 + 32'(rd_seq);
                        rd_seq++;
                    end
                end
            end
            if (o_start) begin
                if (n_txn < 64) begin
                    log_we[n_txn]    = o_we;
                    log_addr[n_txn]  = o_addr;
                    log_wdata[n_txn] = o_wdata;
                    log_cyc[n_txn]   = cyc;
                end
                cur_idx = n_txn;
                cur_we  = o_we;
                n_txn++;
                cnt = lat;
            end
            if (o_done_if_set) begin done_cnt++; done_cyc = cyc; end
            if (o_err_if_set) err_cnt++;
            if (o_go_hw_we) hwwe_cnt++;
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_logs();
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    task automatic run_xfer(input logic [31:0] src, input logic [31:0] dest, input int len,
                            input logic sinc, input logic dinc, input int hold);
        i_src_addr = src; i_dest_addr = dest; i_len = LW'(len);
        i_src_inc = sinc; i_dest_inc = dinc;
        i_go = 1'b1;
        go_cyc = cyc;
        repeat (hold) tick();
        i_go = 1'b0;
        for (int i = 0; i < 400 && o_busy; i++) tick();
        checks++;
        if (o_busy !== 1'b0) begin
            failures++;
            $display("FAIL xfer_timeout busy=%b required=0", o_busy);
        end
    endtask

    task automatic test_reset();
        i_rst = 1'b1;
        repeat (3) tick();
        checks++;
        if ({o_busy, o_start, o_we, o_go_hw_we, o_done_if_set, o_err_if_set} !== 6'b0) begin
            failures++;
            $display("FAIL reset_flags got=%b required=000000",
                     {o_busy, o_start, o_we, o_go_hw_we, o_done_if_set, o_err_if_set});
        end
        checks++;
        if ({o_addr, o_wdata, o_remaining} !== '0) begin
            failures++;
            $display("FAIL reset_buses addr=%h wdata=%h rem=%0d required=0", o_addr, o_wdata, o_remaining);
        end
        i_rst = 1'b0;
        tick();
        checks++;
        if (o_busy !== 1'b0) begin failures++; $display("FAIL reset_idle busy=%b required=0", o_busy); end
    endtask

    task automatic test_basic();
        clear_logs();
        lat = 1; err_idx = -1;
        run_xfer(32'h100, 32'h200, 3, 1'b1, 1'b1, 1);
        checks++;
        if (n_txn !== 6) begin failures++; $display("FAIL basic_ntxn got=%0d required=6", n_txn); end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (log_we[i] !== 1'b0 || log_addr[i] !== 32'h100 + 32'(4 * i)) begin
                failures++;
                $display("FAIL basic_read%0d we=%b addr=%h required we=0 addr=%h", i, log_we[i], log_addr[i], 32'h100 + 32'(4 * i));
            end
            checks++;
            if (log_we[i+3] !== 1'b1 || log_addr[i+3] !== 32'h200 + 32'(4 * i) || log_wdata[i+3] !== 32'hC0DE_0000 + 32'(i)) begin
                failures++;
                $display("FAIL basic_write%0d we=%b addr=%h data=%h required we=1 addr=%h data=%h", i,
                         log_we[i+3], log_addr[i+3], log_wdata[i+3], 32'h200 + 32'(4 * i), 32'hC0DE_0000 + 32'(i));
            end
        end
        checks++;
        if (log_cyc[0] - go_cyc !== 2) begin failures++; $display("FAIL basic_latency got=%0d required=2", log_cyc[0] - go_cyc); end
        checks++;
        if (done_cnt !== 1 || err_cnt !== 0 || hwwe_cnt !== 1) begin
            failures++;
            $display("FAIL basic_pulses done=%0d err=%0d hwwe=%0d required 1/0/1", done_cnt, err_cnt, hwwe_cnt);
        end
        checks++;
        if (done_cyc - log_cyc[5] !== lat + 1) begin failures++; $display("FAIL basic_done_timing got=%0d required=%0d", done_cyc - log_cyc[5], lat + 1); end
        checks++;
        if (o_remaining !== 16'd0) begin failures++; $display("FAIL basic_remaining got=%0d required=0", o_remaining); end
    endtask

    task automatic test_chunks();
        int rem, rd, wr, e, c;
        clear_logs();
        lat = 2; err_idx = -1;
        run_xfer(32'h1000, 32'h2000, 10, 1'b1, 1'b1, 1);
        checks++;
        if (n_txn !== 20) begin failures++; $display("FAIL chunk_ntxn got=%0d required=20", n_txn); end
        rem = 10; rd = 0; wr = 0; e = 0;
        while (rem > 0) begin
            c = (rem > BL) ? BL : rem;
            for (int i = 0; i < c; i++) begin
                checks++;
                if (log_we[e] !== 1'b0 || log_addr[e] !== 32'h1000 + 32'(4 * rd)) begin
                    failures++;
                    $display("FAIL chunk_txn%0d we=%b addr=%h required read at %h", e, log_we[e], log_addr[e], 32'h1000 + 32'(4 * rd));
                end
                e++; rd++;
            end
            for (int i = 0; i < c; i++) begin
                checks++;
                if (log_we[e] !== 1'b1 || log_addr[e] !== 32'h2000 + 32'(4 * wr) || log_wdata[e] !== 32'hC0DE_0000 + 32'(wr)) begin
                    failures++;
                    $display("FAIL chunk_txn%0d we=%b addr=%h data=%h required write at %h data %h", e,
                             log_we[e], log_addr[e], log_wdata[e], 32'h2000 + 32'(4 * wr), 32'hC0DE_0000 + 32'(wr));
                end
                e++; wr++;
            end
            rem -= c;
        end
        checks++;
        if (log_cyc[1] - log_cyc[0] !== lat + 1) begin failures++; $display("FAIL chunk_read_cost got=%0d required=%0d", log_cyc[1] - log_cyc[0], lat + 1); end
        checks++;
        if (log_cyc[5] - log_cyc[4] !== lat + 1) begin failures++; $display("FAIL chunk_write_cost got=%0d required=%0d", log_cyc[5] - log_cyc[4], lat + 1); end
        checks++;
        if (done_cnt !== 1) begin failures++; $display("FAIL chunk_done got=%0d required=1", done_cnt); end
    endtask

    task automatic test_fixed_src();
        clear_logs();
        lat = 3; err_idx = -1;
        run_xfer(32'h300, 32'h400, 4, 1'b0, 1'b1, 1);
        checks++;
        if (n_txn !== 8) begin failures++; $display("FAIL fixed_ntxn got=%0d required=8", n_txn); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (log_addr[i] !== 32'h300 || log_addr[i+4] !== 32'h400 + 32'(4 * i)) begin
                failures++;
                $display("FAIL fixed_addr%0d rd=%h wr=%h required rd=300 wr=%h", i, log_addr[i], log_addr[i+4], 32'h400 + 32'(4 * i));
            end
        end
    endtask

    task automatic test_write_err();
        clear_logs();
        lat = 1; err_idx = 5;
        run_xfer(32'h500, 32'h600, 5, 1'b1, 1'b1, 1);
        err_idx = -1;
        checks++;
        if (err_cnt !== 1 || done_cnt !== 0) begin failures++; $display("FAIL werr_pulses err=%0d done=%0d required 1/0", err_cnt, done_cnt); end
        checks++;
        if (o_remaining !== 16'd4) begin failures++; $display("FAIL werr_remaining got=%0d required=4", o_remaining); end
        checks++;
        if (n_txn !== 6) begin failures++; $display("FAIL werr_ntxn got=%0d required=6", n_txn); end
    endtask

    task automatic test_abort();
        clear_logs();
        lat = 1; err_idx = -1;
        i_src_addr = 32'h700; i_dest_addr = 32'h800; i_len = 16'd3;
        i_src_inc = 1'b1; i_dest_inc = 1'b1;
        i_go = 1'b1;
        tick();
        i_go = 1'b0;
        for (int i = 0; i < 20 && n_txn < 1; i++) tick();
        tick();
        i_abort = 1'b1;
        for (int i = 0; i < 50 && o_busy; i++) tick();
        i_abort = 1'b0;
        checks++;
        if (n_txn !== 1) begin failures++; $display("FAIL abort_ntxn got=%0d required=1", n_txn); end
        checks++;
        if (err_cnt !== 1 || done_cnt !== 0) begin failures++; $display("FAIL abort_pulses err=%0d done=%0d required 1/0", err_cnt, done_cnt); end
        checks++;
        if (o_remaining !== 16'd3) begin failures++; $display("FAIL abort_remaining got=%0d required=3", o_remaining); end
    endtask

    task automatic test_len0();
        clear_logs();
        run_xfer(32'h10, 32'h20, 0, 1'b1, 1'b1, 1);
        checks++;
        if (done_cnt !== 1 || n_txn !== 0) begin failures++; $display("FAIL len0 done=%0d ntxn=%0d required 1/0", done_cnt, n_txn); end
        checks++;
        if (done_cyc - go_cyc !== 2) begin failures++; $display("FAIL len0_timing got=%0d required=2", done_cyc - go_cyc); end
    endtask

    task automatic test_go_held();
        clear_logs();
        lat = 1;
        run_xfer(32'h900, 32'hA00, 2, 1'b1, 1'b1, 20);
        repeat (5) tick();
        checks++;
        if (n_txn !== 4 || done_cnt !== 1) begin failures++; $display("FAIL go_held ntxn=%0d done=%0d required 4/1", n_txn, done_cnt); end
    endtask

    task automatic test_reset_mid();
        clear_logs();
        lat = 5;
        i_src_addr = 32'hB00; i_dest_addr = 32'hC00; i_len = 16'd4;
        i_src_inc = 1'b1; i_dest_inc = 1'b1;
        i_go = 1'b1;
        tick();
        i_go = 1'b0;
        for (int i = 0; i < 100 && n_txn < 5; i++) tick();
        tick();
        i_rst = 1'b1;
        tick();
        checks++;
        if ({o_busy, o_start, o_we, o_addr, o_wdata, o_remaining} !== '0) begin
            failures++;
            $display("FAIL rstmid_outputs busy=%b start=%b we=%b addr=%h wdata=%h rem=%0d required all 0",
                     o_busy, o_start, o_we, o_addr, o_wdata, o_remaining);
        end
        tick();
        i_rst = 1'b0;
        repeat (8) tick();
        checks++;
        if (o_busy !== 1'b0 || n_txn !== 5) begin failures++; $display("FAIL rstmid_idle busy=%b ntxn=%0d required 0/5", o_busy, n_txn); end
        clear_logs();
        lat = 1;
        run_xfer(32'hD00, 32'hE00, 2, 1'b1, 1'b1, 1);
        checks++;
        if (n_txn !== 4 || done_cnt !== 1) begin failures++; $display("FAIL rstmid_restart ntxn=%0d done=%0d required 4/1", n_txn, done_cnt); end
        checks++;
        if (log_addr[2] !== 32'hE00 || log_wdata[3] !== 32'hC0DE_0001) begin
            failures++;
            $display("FAIL rstmid_data addr=%h data=%h required e00/c0de0001", log_addr[2], log_wdata[3]);
        end
    endtask

    task automatic test_wrap();
        clear_logs();
        lat = 1;
        run_xfer(32'hFFFF_FFFC, 32'h40, 2, 1'b1, 1'b1, 1);
        checks++;
        if (log_addr[0] !== 32'hFFFF_FFFC || log_addr[1] !== 32'h0) begin
            failures++;
            $display("FAIL wrap addr0=%h addr1=%h required fffffffc/00000000", log_addr[0], log_addr[1]);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_chunks();
        test_fixed_src();
        test_write_err();
        test_abort();
        test_len0();
        test_go_held();
        test_reset_mid();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
